// File: rtl/contador_modular_if.sv
// contador_modular_if: control and status bundle of contador_modular.
interface contador_modular_if #(
    parameter int BITS = 4
);
    logic Enable, Up, Sat, Load;
    logic [BITS-1:0] Din, count;
    logic carry, tc, ovf;
    modport master (output Enable, Up, Sat, Load, Din, input count, carry, tc, ovf);
    modport slave (input Enable, Up, Sat, Load, Din, output count, carry, tc, ovf);
endinterface

// File: rtl/contador_modular.sv
// contador_modular: modulo-MODULO up/down counter with load clamp, wrap/saturate, carry, tc and sticky ovf.
// Defining CONTADOR_PRESCALER_EN makes only every PRESCALE-th enabled edge a count step.
module contador_modular #(
    parameter int BITS     = 4,
    parameter int MODULO   = 10,
    parameter int PRESCALE = 1
) (
    input logic NEclk,
    input logic Nreset,
    contador_modular_if.slave bus
);
    localparam logic [BITS-1:0] TOP = BITS'(MODULO - 1);
    logic [BITS-1:0] count, nxt;
    logic tc, ovf, tick, step, at_bound;
`ifdef CONTADOR_PRESCALER_EN
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pre;
    assign tick = bus.Enable & (pre == PW'(PRESCALE - 1));
    always_ff @(negedge NEclk) begin
        if (!Nreset || bus.Load) pre <= '0;
        else if (bus.Enable) pre <= tick ? '0 : pre + PW'(1);
    end
`else
    // Without a prescaler every enabled edge steps; a non-positive PRESCALE is illegal and stalls.
    assign tick = PRESCALE >= 1;
`endif
    assign step = bus.Enable & tick;
    assign at_bound = bus.Up ? count == TOP : count == '0;
    assign nxt = at_bound ? (bus.Sat ? count : (bus.Up ? '0 : TOP))
                          : (bus.Up ? count + BITS'(1) : count - BITS'(1));
    always_ff @(negedge NEclk) begin
        if (!Nreset) begin
            count <= '0;
            tc <= 1'b0;
            ovf <= 1'b0;
        end else if (bus.Load) begin
            count <= bus.Din > TOP ? TOP : bus.Din;
            tc <= 1'b0;
            ovf <= 1'b0;
        end else begin
            tc <= step & at_bound;
            if (step) count <= nxt;
            if (step & at_bound & ~bus.Sat) ovf <= 1'b1;
        end
    end
    assign bus.count = count;
    assign bus.carry = step & at_bound;
    assign bus.tc = tc;
    assign bus.ovf = ovf;
endmodule

// File: tb/tb_contador_modular.sv
// tb_contador_modular: randomized and directed checks of contador_modular against an arithmetic model.
module tb_contador_modular;
`ifdef CONTADOR_PRESCALER_EN
    localparam int P = 3;
`else
    localparam int P = 1;
`endif
    localparam int M = 10;
    logic clk = 1'b0;
    logic Nreset = 1'b0;
    int total = 0;
    int passed = 0;
    int m_count = 0;
    int m_ps = 0;
    bit m_tc = 1'b0;
    bit m_ovf = 1'b0;

    contador_modular_if #(.BITS(4)) bus ();
    contador_modular #(.BITS(4), .MODULO(M), .PRESCALE(3)) dut (
        .NEclk(clk),
        .Nreset(Nreset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic bit bound_now();
        return bus.Up ? m_count == M - 1 : m_count == 0;
    endfunction

    function automatic bit exp_carry();
        return bus.Enable && m_ps == P - 1 && bound_now();
    endfunction

    task automatic drive(input bit en, input bit up, input bit sat, input bit load, input logic [3:0] din);
        bus.Enable = en;
        bus.Up = up;
        bus.Sat = sat;
        bus.Load = load;
        bus.Din = din;
        #1;
    endtask

    // Model applies the stated rules at the falling edge, then returns shortly after the next rising edge.
    task automatic advance();
        int nxt;
        bit step, bnd;
        @(negedge clk);
        if (!Nreset) begin
            m_count = 0; m_ps = 0; m_tc = 1'b0; m_ovf = 1'b0;
        end else if (bus.Load) begin
            m_count = bus.Din >= M ? M - 1 : int'(bus.Din);
            m_ps = 0; m_tc = 1'b0; m_ovf = 1'b0;
        end else begin
            step = bus.Enable && m_ps == P - 1;
            bnd = bound_now();
            if (bus.Enable) m_ps = (m_ps + 1) % P;
            m_tc = step && bnd;
            if (step) begin
                nxt = m_count + (bus.Up ? 1 : -1);
                if (nxt < 0 || nxt >= M) begin
                    if (bus.Sat) nxt = m_count;
                    else begin
                        nxt = (nxt + M) % M;
                        m_ovf = 1'b1;
                    end
                end
                m_count = nxt;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        Nreset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        advance();
        total++;
        if ({bus.count, bus.tc, bus.ovf} !== 6'b0) $display("FAIL reset_init: got %h/%b/%b want 0/0/0", bus.count, bus.tc, bus.ovf);
        else passed++;
        Nreset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
        advance();
        total++;
        if (bus.count !== 4'd7) $display("FAIL reset_load7: got %0d want 7", bus.count);
        else passed++;
        Nreset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        total++;
        if (bus.count !== 4'd7) $display("FAIL reset_midcycle: got %0d want 7", bus.count);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
            advance();
            total++;
            if ({bus.count, bus.tc, bus.ovf} !== 6'b0) $display("FAIL reset_hold edge %0d: got %h/%b/%b want 0/0/0", i, bus.count, bus.tc, bus.ovf);
            else passed++;
        end
        Nreset = 1'b1;
    endtask

    task automatic test_up_wrap();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        advance();
        for (int i = 0; i < 10 * P; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
            total++;
            if (bus.carry !== exp_carry()) $display("FAIL up_wrap_carry edge %0d: got %b want %b", i, bus.carry, exp_carry());
            else passed++;
            advance();
            total++;
            if ({bus.count, bus.tc, bus.ovf} !== {4'(m_count), m_tc, m_ovf})
                $display("FAIL up_wrap edge %0d: got %0d/%b/%b want %0d/%b/%b", i, bus.count, bus.tc, bus.ovf, m_count, m_tc, m_ovf);
            else passed++;
        end
        total++;
        if ({bus.count, bus.tc, bus.ovf} !== {4'd0, 1'b1, 1'b1}) $display("FAIL up_wrap_end: got %0d/%b/%b want 0/1/1", bus.count, bus.tc, bus.ovf);
        else passed++;
    endtask

    task automatic test_load();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd13);
        advance();
        total++;
        if ({bus.count, bus.ovf, bus.tc} !== {4'd9, 1'b0, 1'b0}) $display("FAIL load_clamp: got %0d/%b/%b want 9/0/0", bus.count, bus.ovf, bus.tc);
        else passed++;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
        total++;
        if (bus.carry !== exp_carry()) $display("FAIL load_carry: got %b want %b", bus.carry, exp_carry());
        else passed++;
        advance();
        total++;
        if ({bus.count, bus.tc} !== {4'd5, 1'b0}) $display("FAIL load_5: got %0d/%b want 5/0", bus.count, bus.tc);
        else passed++;
    endtask

    task automatic test_down_sat();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd2);
        advance();
        for (int i = 0; i < 4 * P; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
            total++;
            if (bus.carry !== exp_carry()) $display("FAIL down_sat_carry edge %0d: got %b want %b", i, bus.carry, exp_carry());
            else passed++;
            advance();
            total++;
            if ({bus.count, bus.tc, bus.ovf} !== {4'(m_count), m_tc, m_ovf})
                $display("FAIL down_sat edge %0d: got %0d/%b/%b want %0d/%b/%b", i, bus.count, bus.tc, bus.ovf, m_count, m_tc, m_ovf);
            else passed++;
        end
        total++;
        if ({bus.count, bus.tc, bus.ovf} !== {4'd0, 1'b1, 1'b0}) $display("FAIL down_sat_end: got %0d/%b/%b want 0/1/0", bus.count, bus.tc, bus.ovf);
        else passed++;
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd4);
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            total++;
            if (bus.carry !== 1'b0) $display("FAIL hold_carry edge %0d: got %b want 0", i, bus.carry);
            else passed++;
            advance();
            total++;
            if ({bus.count, bus.tc} !== {4'd4, 1'b0}) $display("FAIL hold edge %0d: got %0d/%b want 4/0", i, bus.count, bus.tc);
            else passed++;
        end
    endtask

    task automatic test_prescaler();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        advance();
        for (int i = 0; i < 9; i++) begin
            drive(i != 1, 1'b1, 1'b0, 1'b0, 4'd0);
            advance();
            total++;
            if (bus.count !== 4'(m_count)) $display("FAIL prescaler edge %0d: got %0d want %0d", i, bus.count, m_count);
            else passed++;
        end
        total++;
        if (bus.count !== 4'(8 / P)) $display("FAIL prescaler_end: got %0d want %0d", bus.count, 8 / P);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Nreset = $urandom_range(31) != 0;
            drive($urandom_range(3) != 0, 1'($urandom), 1'($urandom), $urandom_range(15) == 0, 4'($urandom_range(15)));
            total++;
            if (bus.carry !== exp_carry()) $display("FAIL random_carry %0d: got %b want %b", i, bus.carry, exp_carry());
            else passed++;
            advance();
            total++;
            if ({bus.count, bus.tc, bus.ovf} !== {4'(m_count), m_tc, m_ovf})
                $display("FAIL random %0d: got %0d/%b/%b want %0d/%b/%b", i, bus.count, bus.tc, bus.ovf, m_count, m_tc, m_ovf);
            else passed++;
        end
        Nreset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_load();
        test_down_sat();
        test_hold();
        test_prescaler();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/contador_modular.md
# contador_modular

Parametrised modulo-N up/down counter. It generalises the basic enable-gated up counter with a programmable modulus, count direction, wrap or saturate mode, synchronous load, a cascade carry and terminal-count/overflow flags. It sits in the counting datapath: single instances drive display digits, and chained instances (carry into the next Enable) build multi-digit BCD or arbitrary-radix counters.

## Interface
- BITS, 4: width of count and Din.
- MODULO, 10: count range 0..MODULO-1. Legal range is 2 ≤ MODULO ≤ 2^BITS.
- PRESCALE, 1: enabled edges per count step. Must be ≥ 1. Effective only with CONTADOR_PRESCALER_EN.
- NEclk  in  1  clock; all state updates on the negative edge.
- Nreset  in  1  reset Nreset, synchronous, active-low.
- Enable  in  1  count enable; also advances the prescaler.
- Up  in  1  direction: 1 = up, 0 = down.
- Sat  in  1  boundary mode: 1 = saturate, 0 = wrap.
- Load  in  1  synchronous load of Din.
- Din  in  BITS  load value.
- count  out  BITS  registered count value.
- carry  out  1  combinational cascade strobe.
- tc  out  1  registered terminal-count pulse.
- ovf  out  1  sticky wrap flag.

## Operation
- Internal signals:
  - tick: prescaler strobe; constant 1 without the macro.
  - step = Enable & tick.
  - at_bound = Up ? (count == MODULO-1) : (count == 0).
- Priority at each negedge: Nreset=0, then Load=1, then step=1, else hold.
- Reset: count=0, tc=0, ovf=0, prescaler=0.
- Load:
  - count <= Din when Din < MODULO; otherwise count <= MODULO-1 (clamp).
  - ovf <= 0, tc <= 0, prescaler <= 0.
  - Load wins over a simultaneous step.
- Step, up: count+1 when not at_bound. At MODULO-1: wraps to 0 if Sat=0, holds if Sat=1.
- Step, down: count-1 when not at_bound. At 0: wraps to MODULO-1 if Sat=0, holds if Sat=1.
- tc <= step & at_bound & ~Load. It pulses for every boundary event, including held saturation attempts. Otherwise tc <= 0.
- ovf is set on a wrap (step & at_bound & Sat=0) and holds until Nreset or Load.
- carry = step & at_bound, combinational. Not gated by Load. Feed it to the next stage's Enable.
- Enable=0 holds count and prescaler; tc returns to 0.
- Arithmetic is done in BITS bits. Comparisons use MODULO-1 truncated to BITS. Count never leaves 0..MODULO-1.
- No intra-assignment delays.

## Timing
- Latency: count, tc and ovf reflect inputs sampled at a negedge immediately after that edge. This is one-edge latency.
- carry is valid during the low-to-high phase before the edge that performs the boundary step. A cascaded stage sharing NEclk steps on that same edge.
- Nreset is sampled only at negedges. Asserting it mid-count has no effect until the next negedge, where all outputs clear.
- Up, Sat, Load and Din must be stable around each negedge. Changing Up or Sat between edges is legal and takes effect at the next step.

## Configuration
- CONTADOR_PRESCALER_EN defined:
  - Prescaler register sized for PRESCALE-1, counting 0..PRESCALE-1 on each negedge with Enable=1.
  - tick = Enable & (prescaler == PRESCALE-1); the prescaler wraps to 0 on tick.
  - Cleared by Nreset and Load.
  - PRESCALE=1 behaves exactly like the macro absent.
- CONTADOR_PRESCALER_EN undefined: no prescaler logic, tick=1, and every enabled edge is a step. PRESCALE is ignored.

## Test plan
All scenarios use BITS=4, MODULO=10.
- Reset: count at 7, Nreset=0 driven low mid-cycle. count stays 7 until the next negedge, then count=0, tc=0, ovf=0. It holds 0 while Nreset=0 even with Enable=1.
- Up wrap: Up=1, Sat=0, Enable=1 from 0 for 10 edges gives 1,2,…,9,0. carry=1 only while count=9. tc=1 for exactly one cycle after 9→0. ovf=1 and stays 1.
- Down saturate: Load Din=2, then Up=0, Sat=1, Enable=1 for 4 edges gives 1,0,0,0. tc=1 after each held edge at 0. ovf stays 0.
- Load priority and clamp: Load=1, Din=13, Enable=1 gives count=9 and ovf cleared. Then Load=1, Din=5 gives count=5.
- Hold: count=4, Enable=0 for 5 edges. count stays 4, carry=0, tc=0.
- Prescaler (macro on, PRESCALE=3): Enable=1 for 9 edges from 0 gives count=3, incrementing on edges 3, 6 and 9. Enable=0 on edge 2 delays the first increment by one edge.
